xalu_ctrl: RTL
==============

XALU_CTRL -- requirements
Module: xalu_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 5: number of busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: number of busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin the operation given by op.
REQ-006 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7=reserved.
REQ-007 A  input  32  rs operand.
REQ-008 B  input  32  rt operand.
REQ-009 busy  output  1  registered; high while an operation is in progress.
REQ-010 HI  output  32  registered HI register value.
REQ-011 LO  output  32  registered LO register value.

Function
REQ-012 The FSM SHALL have three states: IDLE, MUL, DIV.
REQ-013 In IDLE with start=1 and op in {0,1}, the block SHALL:
- latch A and B;
- load the counter with MUL_CYCLES;
- enter MUL at the same edge.
REQ-014 In IDLE with start=1 and op in {2,3}, the block SHALL latch the operands, load the counter with DIV_CYCLES and enter DIV.
REQ-015 busy SHALL be 1 exactly when the state is MUL or DIV, so it is high for exactly MUL_CYCLES or DIV_CYCLES consecutive cycles beginning the cycle after start.
REQ-016 The counter SHALL decrement by 1 each cycle in MUL or DIV; at the edge where it reaches 1, the state SHALL return to IDLE and HI/LO SHALL be written, so results are visible in the first cycle busy=0.
REQ-017 MULT SHALL compute the signed 64-bit product of the latched operands; MULTU SHALL compute the unsigned product; HI gets bits 63:32 and LO gets bits 31:0.
REQ-018 DIV SHALL compute the signed quotient into LO and the signed remainder into HI, truncating toward zero; the remainder takes the sign of the dividend.
REQ-019 DIVU SHALL compute the unsigned quotient into LO and the unsigned remainder into HI.
REQ-020 Division with latched B=0 SHALL still run the full DIV_CYCLES busy period and SHALL leave HI and LO unchanged.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000.
REQ-022 MTHI with start=1 in IDLE SHALL write A into HI at that edge; MTLO SHALL write A into LO at that edge; busy SHALL stay 0 and the state SHALL stay IDLE.
REQ-023 start while busy=1 SHALL be ignored: no operand latch, no counter reload, no HI/LO write.
REQ-024 start with a reserved op SHALL be ignored.
REQ-025 Computation SHALL use only the latched operands; changes on A and B during busy SHALL not affect the result.
REQ-026 A new start in the first IDLE cycle after completion SHALL be accepted normally, giving back-to-back operations with no dead cycle.
REQ-027 HI and LO SHALL be stable between writes; the result write of REQ-016 is the only write in the completing cycle.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL set state=IDLE, counter=0, busy=0, HI=0, LO=0 and clear the latched operands.
REQ-029 Reset SHALL take priority over start.
REQ-030 Reset during MUL or DIV SHALL abort the operation, discard the pending result, and deassert busy in the following cycle.

Verification
REQ-031 MULT, A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 MULTU, A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-033 DIV, A=-7 (0xFFFFFFF9), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 MTHI A=0x12345678, then DIVU B=0 -> HI stays 0x12345678 and LO stays 0 through and after 10 busy cycles.
REQ-035 MULT started, a second start (DIVU) issued during busy, and A changed mid-operation -> second start ignored, busy ends after exactly 5 cycles, result from the original operands.
REQ-036 DIV started, reset asserted on busy cycle 4 -> busy=0, HI=LO=0 next cycle; a MULT started immediately after completes normally.

Source files
------------

// File: rtl/xalu_ctrl_if.sv
// Request/result bundle between a pipeline front end and the multi-cycle HI/LO unit.
interface xalu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output busy, HI, LO
  );
endinterface

// File: rtl/xalu_ctrl.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair, with MTHI/MTLO moves.
// Results land in HI/LO on the edge that ends the busy period.
module xalu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic         clk,
  input logic         reset,
  xalu_ctrl_if.slave  bus
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              busy_q;

  // Sign-extend only for signed ops; the low 64 bits of the product are then correct for both.
  logic [63:0] ext_a, ext_b, prod;
  assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 r 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign a_neg = sgn_q & a_q[31];
  assign b_neg = sgn_q & b_q[31];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
  assign r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1: begin
              a_d     = bus.A;
              b_d     = bus.B;
              sgn_d   = ~bus.op[0];
              cnt_d   = CntW'(MUL_CYCLES);
              state_d = StMul;
            end
            3'd2, 3'd3: begin
              a_d     = bus.A;
              b_d     = bus.B;
              sgn_d   = ~bus.op[0];
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StDiv;
            end
            3'd4:    hi_d = bus.A;
            3'd5:    lo_d = bus.A;
            default: ;
          endcase
        end
      end
      StMul: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end
      end
      StDiv: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          // Divide by zero burns the full latency but leaves HI/LO untouched.
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
